mdp_datapath: RTL and testbench
===============================

# mdp_datapath

Parametrised multicycle MIPS-style datapath: the next generation of the team's M_datapath, sitting between the multicycle control FSM and the MIO memory/IO bus. Holds PC, IR, MDR, A, B, ALUOut and a register file. Adds configurable data width, register count and reset vector, a memory-wait stall, jal/jr/lui/bne support and an optional debug read port.

## Interface
- XLEN, 32: datapath width; must be ≥32. Instructions stay 32-bit.
- REG_AW, 5: register index width, 3..5; the index is the low REG_AW bits of each instruction field.
- RESET_PC, 0: PC value after reset.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- MIO_ready  in  1  memory ready; 0 freezes all state.
- IorD, IRWrite, RegWrite, ALUSrcA, PCWrite, PCWriteCond, Branch  in  1 each  controller strobes/selects.
- RegDst, MemtoReg, ALUSrcB, PCSource  in  2 each  mux selects.
- ALU_operation  in  3  ALU opcode.
- data2CPU  in  XLEN  memory read data.
- PC_Current  out  XLEN  PC register.
- Inst  out  32  IR register.
- data_out  out  XLEN  B register (store data).
- M_addr  out  XLEN  memory address.
- zero, overflow  out  1 each  ALU flags, combinational.

## Operation
- ALU A input: ALUSrcA 0 = PC, 1 = A.
- ALU B input: ALUSrcB 00 = B, 01 = 4, 10 = sign-extended imm16, 11 = sign-extended imm16 << 2.
- ALU_operation: 000 and, 001 or, 010 add, 011 xor, 100 nor, 110 sub, 111 slt (signed, result 0/1), 101 reserved (result 0).
- zero: ALU result == 0.
- overflow: signed overflow on add/sub only; 0 for all other ops.
- RegDst (write index): 00 rt, 01 rd, 10 all-ones (r31 link), 11 rt.
- MemtoReg (write data): 00 ALUOut, 01 MDR, 10 PC, 11 {imm16, 16'b0} sign-extended to XLEN (lui).
- PCSource (next PC): 00 ALU result, 01 ALUOut, 10 {PC[XLEN-1:28], IR[25:0], 2'b00}, 11 A (jr).
- PC write enable = PCWrite | (PCWriteCond & (Branch ? zero : ~zero)). Branch=1 gives beq; Branch=0 gives bne.
- IR loads data2CPU[31:0] when IRWrite. MDR loads data2CPU every cycle.
- A and B load the register-file reads of rs and rt every cycle. ALUOut loads the ALU result every cycle.
- Register 0 always reads 0; writes to it are discarded.
- M_addr = IorD ? ALUOut : PC, combinational.
- Stall: while MIO_ready=0, PC, IR, MDR, A, B, ALUOut and the register file all hold. Outputs keep presenting held values. The controller must also hold its state.

## Timing
- Reset values: PC_Current = RESET_PC. Inst = 0. data_out = 0. MDR, A, ALUOut and every register = 0. Hence M_addr = RESET_PC with IorD=0.
- Reset wins over MIO_ready and over every write strobe in the same cycle. Reset mid-instruction discards all partial state.
- Latencies: register-file write is visible on the A/B read path the next cycle, and latched into A/B the cycle after. IR write is one cycle. PC update is one cycle.
- Combinational paths: zero, overflow and M_addr are combinational from registers and selects, with no path from data2CPU.
- Simultaneous RegWrite and PC write in one cycle are both performed. MemtoReg=10 uses the pre-update PC.
- PC arithmetic wraps modulo 2^XLEN. Shifts and jump-target concatenation fill with zeros.

## Configuration
- MDP_DEBUG_PORT_EN defined: adds ports dbg_addr (in, REG_AW) and dbg_data (out, XLEN). dbg_data is a combinational read of the register file; 0 for index 0. The port is unaffected by stall.
- Undefined: the ports are absent and the register file has only two read ports.

## Structure
- Shared package mdp_pkg holds:
  - ALU opcode constants;
  - RegDst, MemtoReg, ALUSrcB and PCSource encodings;
  - the r31 link index derivation.
- One sub-module, mdp_alu: purely combinational; XLEN-parametrised; outputs result, zero and overflow.
- The register file stays inline.

## Test plan
- Reset with RESET_PC=0x400: PC_Current=0x400, Inst=0, M_addr=0x400. Then IorD=0, ALUSrcA=0, ALUSrcB=01, ALU_operation=010, PCSource=00, PCWrite=1 → next cycle PC=0x404.
- Load r1=0x7FFFFFFF and r2=1 (XLEN=32). add via A/B: overflow=1, ALUOut=0x80000000. sub r1-r1: zero=1, overflow=0.
- With r3=5, r4=5, PCWriteCond=1, Branch=1, ALUSrcB=11 and imm=0xFFFF: branch taken to PC-4. Same operands with Branch=0: PC unchanged.
- Hold MIO_ready=0 for 3 cycles with IRWrite=1, RegWrite=1, PCWrite=1 and data2CPU=0xDEADBEEF: PC, Inst and registers unchanged. Release: Inst=0xDEADBEEF after one cycle.
- jal: RegDst=10, MemtoReg=10 with PC=0x1000 → r31=0x1000 and PC={0x1000[31:28], target, 00}. jr with A=0x2000 → PC=0x2000. Write to r0 → reads stay 0.
- With MDP_DEBUG_PORT_EN and REG_AW=3: write 0x55 to index 7 via RegDst=10; dbg_addr=7 → dbg_data=0x55. Assert reset mid-sequence → dbg_data=0.

Source files
------------

// File: rtl/mdp_pkg.sv
// rtl/mdp_pkg.sv - shared encodings for the mdp_datapath ALU, write-back and PC muxes
package mdp_pkg;

   localparam logic [2:0] ALU_AND  = 3'b000;
   localparam logic [2:0] ALU_OR   = 3'b001;
   localparam logic [2:0] ALU_ADD  = 3'b010;
   localparam logic [2:0] ALU_XOR  = 3'b011;
   localparam logic [2:0] ALU_NOR  = 3'b100;
   localparam logic [2:0] ALU_RSVD = 3'b101;
   localparam logic [2:0] ALU_SUB  = 3'b110;
   localparam logic [2:0] ALU_SLT  = 3'b111;

   localparam logic [1:0] REGDST_RT   = 2'b00;
   localparam logic [1:0] REGDST_RD   = 2'b01;
   localparam logic [1:0] REGDST_LINK = 2'b10;
   localparam logic [1:0] REGDST_RT_B = 2'b11;

   localparam logic [1:0] MEMTOREG_ALUOUT = 2'b00;
   localparam logic [1:0] MEMTOREG_MDR    = 2'b01;
   localparam logic [1:0] MEMTOREG_PC     = 2'b10;
   localparam logic [1:0] MEMTOREG_LUI    = 2'b11;

   localparam logic [1:0] SRCB_B       = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;
   localparam logic [1:0] PCSRC_REG    = 2'b11;

   // The link register is the highest index, so it shrinks with the register count.
   function automatic logic [4:0] link_index(input int unsigned aw);
      return 5'((32'd1 << aw) - 32'd1);
   endfunction

endpackage

// File: rtl/mdp_alu.sv
// rtl/mdp_alu.sv - combinational ALU with zero and signed-overflow flags
module mdp_alu
   import mdp_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [2:0]      op,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            overflow
);

   logic [XLEN-1:0] sum;
   logic [XLEN-1:0] diff;
   logic            lt;

   assign sum  = a + b;
   assign diff = a - b;
   assign lt   = $signed(a) < $signed(b);

   always_comb begin
      result   = '0;
      overflow = 1'b0;
      case (op)
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_ADD: begin
            result   = sum;
            overflow = (a[XLEN-1] == b[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
         end
         ALU_XOR: result = a ^ b;
         ALU_NOR: result = ~(a | b);
         ALU_SUB: begin
            result   = diff;
            overflow = (a[XLEN-1] != b[XLEN-1]) && (diff[XLEN-1] != a[XLEN-1]);
         end
         ALU_SLT: result = XLEN'(lt);
         default: result = '0;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/mdp_datapath.sv
// rtl/mdp_datapath.sv - parametrised multicycle MIPS-style datapath with memory-wait stall
// Optional register-file debug read port enabled by MDP_DEBUG_PORT_EN.
module mdp_datapath
   import mdp_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter int              REG_AW   = 5,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              MIO_ready,
   input  logic              IorD,
   input  logic              IRWrite,
   input  logic              RegWrite,
   input  logic              ALUSrcA,
   input  logic              PCWrite,
   input  logic              PCWriteCond,
   input  logic              Branch,
   input  logic [1:0]        RegDst,
   input  logic [1:0]        MemtoReg,
   input  logic [1:0]        ALUSrcB,
   input  logic [1:0]        PCSource,
   input  logic [2:0]        ALU_operation,
   input  logic [XLEN-1:0]   data2CPU,
   output logic [XLEN-1:0]   PC_Current,
   output logic [31:0]       Inst,
   output logic [XLEN-1:0]   data_out,
   output logic [XLEN-1:0]   M_addr,
   output logic              zero,
   output logic              overflow
`ifdef MDP_DEBUG_PORT_EN
   ,
   input  logic [REG_AW-1:0] dbg_addr,
   output logic [XLEN-1:0]   dbg_data
`endif
);

   localparam int              NREG      = 1 << REG_AW;
   localparam logic [4:0]      LINK_FULL = link_index(REG_AW);
   localparam logic [REG_AW-1:0] LINK_IDX = LINK_FULL[REG_AW-1:0];

   logic [XLEN-1:0]   pc;
   logic [31:0]       ir;
   logic [XLEN-1:0]   mdr;
   logic [XLEN-1:0]   a_reg;
   logic [XLEN-1:0]   b_reg;
   logic [XLEN-1:0]   alu_out;
   logic [XLEN-1:0]   regs [NREG];

   logic [REG_AW-1:0] rs_idx;
   logic [REG_AW-1:0] rt_idx;
   logic [REG_AW-1:0] rd_idx;
   logic [REG_AW-1:0] wr_idx;
   logic [XLEN-1:0]   rd_a;
   logic [XLEN-1:0]   rd_b;
   logic [XLEN-1:0]   wr_data;
   logic [XLEN-1:0]   imm_sx;
   logic [XLEN-1:0]   lui_val;
   logic [XLEN-1:0]   alu_a;
   logic [XLEN-1:0]   alu_b;
   logic [XLEN-1:0]   alu_result;
   logic [XLEN-1:0]   pc_next;
   logic              pc_we;

   assign rs_idx  = ir[21 +: REG_AW];
   assign rt_idx  = ir[16 +: REG_AW];
   assign rd_idx  = ir[11 +: REG_AW];
   assign imm_sx  = XLEN'($signed(ir[15:0]));
   assign lui_val = XLEN'($signed({ir[15:0], 16'h0000}));

   assign rd_a = (rs_idx == '0) ? '0 : regs[rs_idx];
   assign rd_b = (rt_idx == '0) ? '0 : regs[rt_idx];

   assign alu_a = ALUSrcA ? a_reg : pc;

   always_comb begin
      alu_b = b_reg;
      case (ALUSrcB)
         SRCB_B:       alu_b = b_reg;
         SRCB_FOUR:    alu_b = XLEN'(4);
         SRCB_IMM:     alu_b = imm_sx;
         SRCB_IMM_SL2: alu_b = imm_sx << 2;
         default:      alu_b = b_reg;
      endcase
   end

   mdp_alu #(.XLEN(XLEN)) u_alu (
      .a        (alu_a),
      .b        (alu_b),
      .op       (ALU_operation),
      .result   (alu_result),
      .zero     (zero),
      .overflow (overflow)
   );

   always_comb begin
      wr_idx  = rt_idx;
      wr_data = alu_out;
      pc_next = alu_result;
      case (RegDst)
         REGDST_RD:   wr_idx = rd_idx;
         REGDST_LINK: wr_idx = LINK_IDX;
         default:     wr_idx = rt_idx;
      endcase
      case (MemtoReg)
         MEMTOREG_MDR: wr_data = mdr;
         MEMTOREG_PC:  wr_data = pc;
         MEMTOREG_LUI: wr_data = lui_val;
         default:      wr_data = alu_out;
      endcase
      case (PCSource)
         PCSRC_ALUOUT: pc_next = alu_out;
         PCSRC_JUMP:   pc_next = {pc[XLEN-1:28], ir[25:0], 2'b00};
         PCSRC_REG:    pc_next = a_reg;
         default:      pc_next = alu_result;
      endcase
   end

   // Branch selects the sense of the condition: beq on zero, bne on non-zero.
   assign pc_we = PCWrite | (PCWriteCond & (Branch ? zero : ~zero));

   always_ff @(posedge clk) begin
      if (reset) begin
         pc      <= RESET_PC;
         ir      <= '0;
         mdr     <= '0;
         a_reg   <= '0;
         b_reg   <= '0;
         alu_out <= '0;
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (MIO_ready) begin
         if (IRWrite) begin
            ir <= data2CPU[31:0];
         end
         mdr     <= data2CPU;
         a_reg   <= rd_a;
         b_reg   <= rd_b;
         alu_out <= alu_result;
         if (pc_we) begin
            pc <= pc_next;
         end
         if (RegWrite && (wr_idx != '0)) begin
            regs[wr_idx] <= wr_data;
         end
      end
   end

   assign PC_Current = pc;
   assign Inst       = ir;
   assign data_out   = b_reg;
   assign M_addr     = IorD ? alu_out : pc;

`ifdef MDP_DEBUG_PORT_EN
   assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];
`endif

endmodule

// File: tb/tb_mdp_datapath.sv
// tb/tb_mdp_datapath.sv - scoreboard bench for mdp_datapath against a behavioural model
module tb_mdp_datapath;

   localparam int XLEN = 32;
`ifdef MDP_DEBUG_PORT_EN
   localparam int RAW = 3;
`else
   localparam int RAW = 5;
`endif
   localparam int        NREG   = 1 << RAW;
   localparam bit [31:0] RST_PC = 32'h0000_0400;
   localparam longint    SMAX   = 2147483647;
   localparam longint    SMIN   = -SMAX - 1;

   logic            clk;
   logic            reset;
   logic            MIO_ready;
   logic            IorD, IRWrite, RegWrite, ALUSrcA, PCWrite, PCWriteCond, Branch;
   logic [1:0]      RegDst, MemtoReg, ALUSrcB, PCSource;
   logic [2:0]      ALU_operation;
   logic [31:0]     data2CPU;
   logic [31:0]     PC_Current, Inst, data_out, M_addr;
   logic            zero, overflow;
   logic [RAW-1:0]  dbg_addr;
`ifdef MDP_DEBUG_PORT_EN
   logic [31:0]     dbg_data;
`endif

   mdp_datapath #(.XLEN(XLEN), .REG_AW(RAW), .RESET_PC(RST_PC)) dut (
      .clk           (clk),
      .reset         (reset),
      .MIO_ready     (MIO_ready),
      .IorD          (IorD),
      .IRWrite       (IRWrite),
      .RegWrite      (RegWrite),
      .ALUSrcA       (ALUSrcA),
      .PCWrite       (PCWrite),
      .PCWriteCond   (PCWriteCond),
      .Branch        (Branch),
      .RegDst        (RegDst),
      .MemtoReg      (MemtoReg),
      .ALUSrcB       (ALUSrcB),
      .PCSource      (PCSource),
      .ALU_operation (ALU_operation),
      .data2CPU      (data2CPU),
      .PC_Current    (PC_Current),
      .Inst          (Inst),
      .data_out      (data_out),
      .M_addr        (M_addr),
      .zero          (zero),
      .overflow      (overflow)
`ifdef MDP_DEBUG_PORT_EN
      ,
      .dbg_addr      (dbg_addr),
      .dbg_data      (dbg_data)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit        rst, rdy, iord, irw, rw, srca, pcw, pcwc, br;
      bit [1:0]  rdst, m2r, srcb, pcs;
      bit [2:0]  op;
      bit [31:0] d;
   } ctrl_t;

   typedef struct {
      bit [31:0] pc, inst, dout, maddr, dbg;
      bit        z, ov;
   } exp_t;

   exp_t      q[$];
   int        nvec = 0;
   int        nbad = 0;

   // Architectural model state
   bit [31:0] mpc, mir, mmdr, ma, mb, maluout;
   bit [31:0] rm [NREG];

   function automatic void ref_alu(input bit [2:0] op, input bit [31:0] x, input bit [31:0] y,
                                   output bit [31:0] r, output bit ov);
      longint sx = longint'($signed(x));
      longint sy = longint'($signed(y));
      longint t  = 0;
      ov = 1'b0;
      r  = 32'h0;
      case (op)
         3'd0: r = x & y;
         3'd1: r = x | y;
         3'd2: begin t = sx + sy; r = t[31:0]; ov = (t > SMAX) || (t < SMIN); end
         3'd3: r = x ^ y;
         3'd4: r = ~(x | y);
         3'd6: begin t = sx - sy; r = t[31:0]; ov = (t > SMAX) || (t < SMIN); end
         3'd7: r = (sx < sy) ? 32'd1 : 32'd0;
         default: r = 32'h0;
      endcase
   endfunction

   function automatic void ref_comb(input ctrl_t c, output bit [31:0] r, output bit ov);
      bit [31:0] x, y, imm;
      imm = {{16{mir[15]}}, mir[15:0]};
      x = c.srca ? ma : mpc;
      case (c.srcb)
         2'd0: y = mb;
         2'd1: y = 32'd4;
         2'd2: y = imm;
         default: y = imm * 4;
      endcase
      ref_alu(c.op, x, y, r, ov);
   endfunction

   function automatic void model_step(input ctrl_t c);
      bit [31:0] r, wd, npc;
      bit        ov, z, pcwe;
      int        rs, rt, rd, wi;
      if (c.rst) begin
         mpc = RST_PC; mir = 0; mmdr = 0; ma = 0; mb = 0; maluout = 0;
         for (int i = 0; i < NREG; i++) rm[i] = 0;
         return;
      end
      if (!c.rdy) return;
      ref_comb(c, r, ov);
      z    = (r == 0);
      pcwe = c.pcw || (c.pcwc && (c.br ? z : !z));
      rs = int'((mir >> 21) % NREG);
      rt = int'((mir >> 16) % NREG);
      rd = int'((mir >> 11) % NREG);
      wi = (c.rdst == 2'd1) ? rd : (c.rdst == 2'd2) ? NREG - 1 : rt;
      case (c.m2r)
         2'd0: wd = maluout;
         2'd1: wd = mmdr;
         2'd2: wd = mpc;
         default: wd = {mir[15:0], 16'h0};
      endcase
      case (c.pcs)
         2'd0: npc = r;
         2'd1: npc = maluout;
         2'd2: npc = {mpc[31:28], mir[25:0], 2'b00};
         default: npc = ma;
      endcase
      ma = rm[rs];
      mb = rm[rt];
      if (c.rw && wi != 0) rm[wi] = wd;
      if (c.irw) mir = c.d;
      mmdr    = c.d;
      maluout = r;
      if (pcwe) mpc = npc;
   endfunction

   function automatic ctrl_t idle();
      ctrl_t c;
      c = '{default: 0};
      c.rdy = 1'b1;
      return c;
   endfunction

   function automatic bit [31:0] itype(input int rs, input int rt, input bit [15:0] imm);
      return {6'h08, 5'(rs), 5'(rt), imm};
   endfunction

   function automatic bit [31:0] rtype(input int rs, input int rt, input int rd);
      return {6'h00, 5'(rs), 5'(rt), 5'(rd), 11'h0};
   endfunction

   task automatic apply(input ctrl_t c, input bit chk);
      exp_t      e;
      bit [31:0] r;
      bit        ov;
      reset = c.rst; MIO_ready = c.rdy; IorD = c.iord; IRWrite = c.irw; RegWrite = c.rw;
      ALUSrcA = c.srca; PCWrite = c.pcw; PCWriteCond = c.pcwc; Branch = c.br;
      RegDst = c.rdst; MemtoReg = c.m2r; ALUSrcB = c.srcb; PCSource = c.pcs;
      ALU_operation = c.op; data2CPU = c.d;
      dbg_addr = RAW'($urandom);
      if (chk) begin
         ref_comb(c, r, ov);
         e.pc    = mpc;
         e.inst  = mir;
         e.dout  = mb;
         e.maddr = c.iord ? maluout : mpc;
         e.z     = (r == 0);
         e.ov    = ov;
         e.dbg   = rm[dbg_addr];
         q.push_back(e);
      end
      @(posedge clk);
      model_step(c);
      #1;
   endtask

   task automatic load_reg(input int idx, input bit [31:0] val);
      ctrl_t c;
      c = idle(); c.irw = 1; c.d = itype(0, idx, 16'h0); apply(c, 1);
      c = idle(); c.d = val;                             apply(c, 1);
      c = idle(); c.rw = 1; c.m2r = 2'd1;                apply(c, 1);
   endtask

   task automatic set_ir(input bit [31:0] w);
      ctrl_t c;
      c = idle(); c.irw = 1; c.d = w; apply(c, 1);
      apply(idle(), 1);
   endtask

   function automatic void chk(input string name, input bit [31:0] act, input bit [31:0] req);
      nvec++;
      if (act !== req) begin
         nbad++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
      end
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("pc", PC_Current, e.pc);
         chk("inst", Inst, e.inst);
         chk("data_out", data_out, e.dout);
         chk("m_addr", M_addr, e.maddr);
         chk("zero", 32'(zero), 32'(e.z));
         chk("overflow", 32'(overflow), 32'(e.ov));
`ifdef MDP_DEBUG_PORT_EN
         chk("dbg_data", dbg_data, e.dbg);
`endif
      end
   end

   initial begin
      ctrl_t c;
      c = idle(); c.rst = 1;
      apply(c, 0);
      apply(c, 1);

      // PC + 4 from the reset vector
      c = idle(); c.srcb = 2'd1; c.op = 3'd2; c.pcw = 1;
      apply(c, 1);
      apply(idle(), 1);

      // signed overflow on add, zero on self-subtract
      load_reg(1, 32'h7FFF_FFFF);
      load_reg(2, 32'h0000_0001);
      set_ir(rtype(1, 2, 0));
      c = idle(); c.srca = 1; c.op = 3'd2; apply(c, 1);
      c = idle(); c.iord = 1; apply(c, 1);
      set_ir(rtype(1, 1, 0));
      c = idle(); c.srca = 1; c.op = 3'd6; apply(c, 1);

      // beq taken to PC-4, then bne not taken on equal operands
      load_reg(3, 32'd5);
      load_reg(4, 32'd5);
      set_ir(itype(3, 4, 16'hFFFF));
      for (int k = 0; k < 2; k++) begin
         c = idle(); c.srcb = 2'd3; c.op = 3'd2; apply(c, 1);
         c = idle(); c.srca = 1; c.op = 3'd6; c.pcwc = 1; c.br = (k == 0); c.pcs = 2'd1;
         apply(c, 1);
         apply(idle(), 1);
      end

      // memory stall with every write strobe active
      for (int k = 0; k < 3; k++) begin
         c = idle(); c.rdy = 0; c.irw = 1; c.rw = 1; c.pcw = 1; c.d = 32'hDEAD_BEEF;
         apply(c, 1);
      end
      c = idle(); c.irw = 1; c.d = 32'hDEAD_BEEF; apply(c, 1);
      apply(idle(), 1);

      // jr to 0x1000, jal from there, jr to 0x2000
      load_reg(5, 32'h0000_1000);
      set_ir(itype(5, 0, 16'h0));
      c = idle(); c.pcw = 1; c.pcs = 2'd3; apply(c, 1);
      set_ir({6'h03, 26'h0ABCDE});
      c = idle(); c.rw = 1; c.rdst = 2'd2; c.m2r = 2'd2; c.pcw = 1; c.pcs = 2'd2; apply(c, 1);
      set_ir(itype(0, NREG - 1, 16'h0));
      load_reg(6, 32'h0000_2000);
      set_ir(itype(6, 0, 16'h0));
      c = idle(); c.pcw = 1; c.pcs = 2'd3; apply(c, 1);

      // r0 writes discarded; lui sign-extension
      load_reg(0, 32'h0000_1234);
      set_ir(itype(0, 0, 16'h0));
      set_ir(itype(0, 9, 16'h8001));
      c = idle(); c.rw = 1; c.m2r = 2'd3; apply(c, 1);
      set_ir(itype(0, 9, 16'h0));

      // link-register write then reset mid-sequence
      load_reg(NREG - 1, 32'h0000_0055);
      c = idle(); c.rst = 1; apply(c, 1);
      apply(idle(), 1);

      for (int n = 0; n < 3000; n++) begin
         c.rst  = ($urandom_range(99) == 0);
         c.rdy  = ($urandom_range(7) != 0);
         c.iord = 1'($urandom); c.irw  = 1'($urandom); c.rw   = 1'($urandom);
         c.srca = 1'($urandom); c.pcw  = 1'($urandom); c.pcwc = 1'($urandom);
         c.br   = 1'($urandom);
         c.rdst = 2'($urandom); c.m2r  = 2'($urandom); c.srcb = 2'($urandom);
         c.pcs  = 2'($urandom); c.op   = 3'($urandom); c.d    = $urandom;
         apply(c, 1);
      end

      @(negedge clk);
      #1;
      nvec++;
      if (q.size() != 0) begin
         nbad++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule
